base_deserializer: RTL

- Receive-side counterpart of the serializer stage. Recovers bytes from the ser_clock / ser_data pair that the serializer drives.
- Oversamples both lines in the single system clock domain and shifts bits in LSB-first, matching the serializer's data[0]-first order.
- Presents each completed byte on a one-entry valid/ready output buffer to downstream logic.
- Flags overrun and mid-byte timeout (frame error).

---
 rtl/base_deserializer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/base_deserializer.sv
// -----------------------------------------------------------------------------
// base_deserializer
//   Receive side of the serializer link. ser_clock and ser_data are
//   oversampled in the system clock domain, rising edges of the synchronized
//   ser_clock shift ser_data in LSB-first, and each completed frame is offered
//   on a one-entry valid/ready buffer.
//
// Ports
//   clock, reset_n   system clock (rising edge) and async active-low reset
//   ser_clock        serial bit clock, asynchronous to clock
//   ser_data         serial data, valid at ser_clock rising edge
//   enable           receive enable; low aborts a partial frame
//   clear_err        pulse; clears overrun and frame_error
//   par_data, valid  output buffer (par_data holds after consumption)
//   ready            downstream accepts when valid & ready
//   busy             a frame is partially received
//   overrun          sticky; a completed frame was dropped (buffer full)
//   frame_error      sticky; a partial frame was discarded by timeout
// -----------------------------------------------------------------------------
module base_deserializer #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  ser_clock,
    input  logic                  ser_data,
    input  logic                  enable,
    input  logic                  clear_err,
    output logic [DATA_WIDTH-1:0] par_data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  busy,
    output logic                  overrun,
    output logic                  frame_error
);
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    // TIMEOUT-1 always fits in clog2(TIMEOUT) bits
    localparam int TMO_W = $clog2(TIMEOUT);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] sdat_sync_q, sdat_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic [0:0]             state_q, state_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [DATA_WIDTH-1:0]  par_q, par_d;
    logic                   valid_q, valid_d;
    logic                   overrun_q, overrun_d;
    logic                   ferr_q, ferr_d;

    logic                   sclk_s;
    logic                   sample;
    logic                   edge_det;
    logic                   done;
    logic [DATA_WIDTH-1:0]  shift_in;

    assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
    assign sample   = sdat_sync_q[SYNC_STAGES-1];
    // Edge detection runs regardless of enable, so a ser_clock already high
    // when enable rises does not look like a fresh edge.
    assign edge_det = sclk_s & ~sclk_prev_q;
    assign shift_in = {sample, shift_q[DATA_WIDTH-1:1]};

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], ser_clock};
        sdat_sync_d = {sdat_sync_q[SYNC_STAGES-2:0], ser_data};
        sclk_prev_d = sclk_s;
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        par_d       = par_q;
        valid_d     = valid_q;
        // A set event below overrides the clear.
        overrun_d   = overrun_q & ~clear_err;
        ferr_d      = ferr_q & ~clear_err;
        done        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable && edge_det) begin
                    shift_d = shift_in;
                    cnt_d   = CNT_W'(1);
                    tmo_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end else if (edge_det) begin
                    // An edge beats a simultaneous timeout.
                    shift_d = shift_in;
                    tmo_d   = '0;
                    if (cnt_q == LAST_CNT) begin
                        done    = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (tmo_q == TMO_MAX) begin
                    ferr_d  = 1'b1;
                    cnt_d   = '0;
                    tmo_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    // Only incremented below TMO_MAX, so it never wraps.
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Output buffer: a completed frame may enter in the same cycle the
        // current entry is consumed.
        if (done && (!valid_q || ready)) begin
            par_d   = shift_in;
            valid_d = 1'b1;
        end else if (done) begin
            overrun_d = 1'b1;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= '0;
            sdat_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            par_q       <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            sdat_sync_q <= sdat_sync_d;
            sclk_prev_q <= sclk_prev_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            par_q       <= par_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            ferr_q      <= ferr_d;
        end
    end

    assign par_data    = par_q;
    assign valid       = valid_q;
    assign busy        = (state_q == ST_SHIFT);
    assign overrun     = overrun_q;
    assign frame_error = ferr_q;

endmodule
